display_timing_gen: RTL
=======================

# display_timing_gen

Raster timing generator that drives the `hcount`/`vcount` bus consumed by every sprite and overlay renderer in the display path, and produces `hsync`/`vsync`/`blank` delayed to line up with the renderers' registered pixel output. It sits between the pixel clock source and the VGA output pins. It is the single source of raster position. It also emits a once-per-frame strobe, used by game logic to update sprite coordinates during vertical blank.

## Interface
- `H_ACTIVE`, 1024, visible pixels per line
- `H_FP`, 24, horizontal front porch (cycles)
- `H_SYNC`, 136, horizontal sync width (cycles)
- `H_BP`, 160, horizontal back porch (cycles); `H_TOTAL` = sum = 1344
- `V_ACTIVE`, 768, visible lines per frame
- `V_FP`, 3, vertical front porch (lines)
- `V_SYNC`, 6, vertical sync width (lines)
- `V_BP`, 29, vertical back porch (lines); `V_TOTAL` = 806
- `PIPE_DELAY`, 2, sync/blank delay in cycles, legal range 1..8; must equal renderer pixel latency
- `pixel_clk` input 1 — the only clock; all registers on the rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `en` input 1 — count enable; low freezes every register in the block
- `hcount` output 11 — current pixel column, 0..H_TOTAL-1
- `vcount` output 10 — current line, 0..V_TOTAL-1
- `hsync` output 1 — active-low horizontal sync, delayed by PIPE_DELAY
- `vsync` output 1 — active-low vertical sync, delayed by PIPE_DELAY
- `blank` output 1 — high outside the active area, delayed by PIPE_DELAY
- `frame_start` output 1 — one-cycle pulse at the start of vertical blank
- `frame_count` output 16 — frames completed since reset, wraps at 65535→0

## Operation
- Counter behaviour with `en` high, on each clock:
  - `hcount` increments by 1.
  - When `hcount == H_TOTAL-1`, `hcount` returns to 0 and `vcount` increments by 1.
  - When `vcount == V_TOTAL-1` at that same wrap, `vcount` returns to 0.
- Raw decode is a combinational function of the current `hcount`/`vcount`:
  - `hs_raw` = 0 when `H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC`, else 1.
  - `vs_raw` = 0 when `V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC`, else 1.
  - `bl_raw` = 1 when `hcount >= H_ACTIVE` or `vcount >= V_ACTIVE`.
- Delay pipeline: a PIPE_DELAY-deep shift register carrying {`hs_raw`, `vs_raw`, `bl_raw`}.
  - `hsync`/`vsync`/`blank` are the raw decode of the `hcount`/`vcount` values presented exactly PIPE_DELAY enabled cycles earlier.
- `frame_start` is registered. It is 1 for exactly the one cycle in which `hcount == 0` and `vcount == V_ACTIVE`.
- `frame_count` increments on the same edge that raises `frame_start`.
- Counter comparisons are unsigned, at full counter width. Parameters must fit the counter widths: `H_TOTAL <= 2048`, `V_TOTAL <= 1024`.
- `en` low:
  - Counters, delay pipeline, `frame_start` and `frame_count` all hold their values.
  - A `frame_start` pulse that is high when `en` falls stays high until the next enabled cycle, then clears.

## Timing
- Reset (`rst_n` low, asynchronous, effective immediately without a clock):
  - `hcount`=0, `vcount`=0, `frame_count`=0, `frame_start`=0.
  - Every pipeline stage holds hs=1, vs=1, bl=1, so `hsync`=1, `vsync`=1, `blank`=1.
- Reset release is synchronous to `pixel_clk`.
- On the first enabled edge after release, `hcount` becomes 1.
- `blank` goes low at the PIPE_DELAY-th enabled edge after release: position (0,0) reaches the output.
- Reset mid-frame: all state returns to reset values in the same instant. No partial line or frame is completed, and `frame_count` does not increment.
- Line wrap and frame wrap happen on the same edge when both counters are at maximum. `vcount` goes to 0, not V_TOTAL.
- `frame_start` period = `H_TOTAL*V_TOTAL` enabled cycles = 1,083,264 at defaults.
- `hsync` low width = `H_SYNC` cycles; `vsync` low width = `V_SYNC*H_TOTAL` cycles.

## Test plan
- Reset: assert `rst_n`=0 mid-line with the clock stopped. → Outputs immediately read 0/0/1/1/1/0/0. Release and apply 5 enabled clocks → `hcount`=5, `vcount`=0.
- Horizontal sync: run from reset with defaults. → `hsync` falls on the edge where the current `hcount` = 1048+2 = 1050 and is low for exactly 136 cycles. `blank` rises when the current `hcount` = 1026.
- Line and frame wrap: small config H 8/1/2/1 (`H_TOTAL`=12), V 4/1/1/1 (`V_TOTAL`=7). → `hcount` sequence 10, 11, 0 with `vcount` +1. At `vcount`=6, `hcount`=11 both counters go to 0 together.
- Frame strobe: small config, run 3 frames. → `frame_start` high exactly 1 cycle per frame, at (`hcount`=0, `vcount`=4). `frame_count` reads 1, 2, 3, and the intervals are 84 cycles.
- Pipeline alignment: `PIPE_DELAY`=1 and `PIPE_DELAY`=5 on the small config. → `blank`/`hsync` equal the raw decode of the `hcount`/`vcount` values PIPE_DELAY cycles earlier, at every cycle over 2 frames. Checked by scoreboard.
- Enable hold: deassert `en` for 10 cycles, including the `frame_start` cycle. → All outputs frozen. `frame_start` clears on the first enabled cycle afterwards and `frame_count` increments only once.

Source files
------------

// File: rtl/display_timing_gen.sv
// Raster timing generator: hcount/vcount position bus plus hsync/vsync/blank
// delayed to match renderer pixel latency, and a once-per-frame strobe.
module display_timing_gen #(
    parameter int unsigned H_ACTIVE   = 1024,
    parameter int unsigned H_FP       = 24,
    parameter int unsigned H_SYNC     = 136,
    parameter int unsigned H_BP       = 160,
    parameter int unsigned V_ACTIVE   = 768,
    parameter int unsigned V_FP       = 3,
    parameter int unsigned V_SYNC     = 6,
    parameter int unsigned V_BP       = 29,
    parameter int unsigned PIPE_DELAY = 2
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int unsigned HW      = 11;
    localparam int unsigned VW      = 10;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_MAX = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW:0]   H_SE  = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_MAX = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW:0]   V_SE  = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    logic          fs_next;
    logic          hs_raw;
    logic          vs_raw;
    logic          bl_raw;

    // Each stage carries {hs, vs, bl}; the last stage drives the outputs.
    logic [PIPE_DELAY-1:0][2:0] pipe;

    // Next raster position, frame strobe condition and raw sync/blank decode.
    always_comb begin
        h_next  = hcount + HW'(1);
        v_next  = vcount;
        if (hcount == H_MAX) begin
            h_next = '0;
            v_next = (vcount == V_MAX) ? '0 : vcount + VW'(1);
        end
        fs_next = (h_next == '0) && (v_next == V_ACT);
        hs_raw  = !((hcount >= H_SS) && ({1'b0, hcount} < H_SE));
        vs_raw  = !((vcount >= V_SS) && ({1'b0, vcount} < V_SE));
        bl_raw  = (hcount >= H_ACT) || (vcount >= V_ACT);
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount      <= '0;
            vcount      <= '0;
            frame_start <= 1'b0;
            frame_count <= '0;
            pipe        <= '1;
        end else if (en) begin
            hcount      <= h_next;
            vcount      <= v_next;
            frame_start <= fs_next;
            if (fs_next) begin
                frame_count <= frame_count + 16'(1);
            end
            for (int i = PIPE_DELAY - 1; i > 0; i--) begin
                pipe[i] <= pipe[i-1];
            end
            pipe[0] <= {hs_raw, vs_raw, bl_raw};
        end
    end

    assign {hsync, vsync, blank} = pipe[PIPE_DELAY-1];

endmodule
